// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller: picks the winning trap at WB, strobes the CSR file,
// then flushes, redirects fetch over a valid/ready handshake and blocks commits for a drain window.
module exc_commit_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic [5:0]  wb_exc,
  input  logic        wb_is_ertn,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_pc,
  output logic        commit_kill,
  output logic        csr_wb_ex,
  output logic        csr_ertn_flush,
  output logic [5:0]  csr_ecode,
  output logic [8:0]  csr_esubcode,
  output logic [31:0] csr_pc,
  output logic [31:0] csr_vaddr,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REDIR, DRAIN} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic        w_trap;
  logic        w_isExc;
  logic [5:0]  w_ecode;
  logic [8:0]  w_esub;
  logic [31:0] w_vaddr;
  logic [31:0] w_redirFirst;
  logic        r_pulse;
  logic        r_isErtn;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esub;
  logic [31:0] r_pc;
  logic [31:0] r_vaddr;
  logic [31:0] r_redirPc;
  logic [3:0]  r_drainCnt;

  // Single-winner priority; ERTN is what remains when no interrupt or exception is present.
  always_comb begin
    w_ecode = 6'h00;
    w_esub  = 9'd0;
    w_vaddr = 32'h0;
    w_isExc = 1'b1;
    if (has_int) begin
      w_ecode = 6'h00;
    end else if (wb_exc[0]) begin
      w_ecode = 6'h08;
      w_vaddr = wb_pc;
    end else if (wb_exc[1]) begin
      w_ecode = 6'h0D;
    end else if (wb_exc[2]) begin
      w_ecode = 6'h0B;
    end else if (wb_exc[3]) begin
      w_ecode = 6'h0C;
    end else if (wb_exc[4]) begin
      w_ecode = 6'h09;
      w_vaddr = wb_vaddr;
    end else if (wb_exc[5]) begin
      w_ecode = 6'h08;
      w_esub  = 9'd1;
      w_vaddr = wb_vaddr;
    end else begin
      w_isExc = 1'b0;
    end
  end

  assign w_trap = (r_state == IDLE) & wb_valid & (has_int | (|wb_exc) | wb_is_ertn);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trap) w_next = REDIR;
      REDIR:   if (redir_ready) w_next = DRAIN;
      DRAIN:   if (r_drainCnt <= 4'd1) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Redirect target is taken live in the first REDIR cycle, then frozen until accepted.
  assign w_redirFirst = r_isErtn ? ertn_pc : ex_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulse    <= 1'b0;
      r_isErtn   <= 1'b0;
      r_ecode    <= 6'h00;
      r_esub     <= 9'd0;
      r_pc       <= 32'h0;
      r_vaddr    <= 32'h0;
      r_redirPc  <= 32'h0;
      r_drainCnt <= 4'd0;
    end else begin
      r_pulse <= w_trap;
      if (w_trap) begin
        r_isErtn <= ~w_isExc;
        if (w_isExc) begin
          r_ecode <= w_ecode;
          r_esub  <= w_esub;
          r_pc    <= wb_pc;
          r_vaddr <= w_vaddr;
        end
      end
      if (r_pulse) r_redirPc <= w_redirFirst;
      if (r_state == REDIR && redir_ready) begin
        r_drainCnt <= DRAIN_LOAD;
      end else if (r_state == DRAIN && r_drainCnt != 4'd0) begin
        r_drainCnt <= r_drainCnt - 4'd1;
      end
    end
  end

  assign commit_kill    = w_trap | ((r_state != IDLE) & wb_valid);
  assign csr_wb_ex      = r_pulse & ~r_isErtn;
  assign csr_ertn_flush = r_pulse & r_isErtn;
  assign flush          = r_pulse;
  assign csr_ecode      = r_ecode;
  assign csr_esubcode   = r_esub;
  assign csr_pc         = r_pc;
  assign csr_vaddr      = r_vaddr;
  assign redir_valid    = (r_state == REDIR);
  assign redir_pc       = r_pulse ? w_redirFirst : r_redirPc;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed scenarios plus randomized traps
// checked against a transaction-level reference model.
module tb_exc_commit_ctrl;

  localparam int DRAIN = 2;
  localparam logic [5:0] CODE_TAB [6] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09, 6'h08};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_vaddr = '0;
  logic [5:0]  wb_exc = '0;
  logic        wb_is_ertn = 1'b0;
  logic        has_int = 1'b0;
  logic [31:0] ex_entry = '0;
  logic [31:0] ertn_pc = '0;
  logic        redir_ready = 1'b0;
  logic        commit_kill, csr_wb_ex, csr_ertn_flush, flush, redir_valid, busy;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic [31:0] csr_pc, csr_vaddr, redir_pc;

  int nChecks = 0;
  int nPass = 0;

  logic [5:0]  heldEcode = '0;
  logic [8:0]  heldSub = '0;
  logic [31:0] heldPc = '0;
  logic [31:0] heldVaddr = '0;

  exc_commit_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .wb_exc(wb_exc), .wb_is_ertn(wb_is_ertn), .has_int(has_int), .ex_entry(ex_entry),
    .ertn_pc(ertn_pc), .commit_kill(commit_kill), .csr_wb_ex(csr_wb_ex),
    .csr_ertn_flush(csr_ertn_flush), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
    .csr_pc(csr_pc), .csr_vaddr(csr_vaddr), .flush(flush), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .redir_ready(redir_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomWb();
    wb_valid   = 1'($urandom);
    wb_exc     = 6'($urandom);
    wb_is_ertn = 1'($urandom);
    has_int    = 1'($urandom);
    wb_pc      = $urandom;
    wb_vaddr   = $urandom;
  endtask

  // Reference model: the architectural winner of a trap, straight from the priority list.
  function automatic void classify(input logic hi, input logic [5:0] ex, input logic [31:0] pc,
                                   input logic [31:0] va, output logic isExc, output logic [5:0] ec,
                                   output logic [8:0] sb, output logic [31:0] bv);
    isExc = 1'b0; ec = '0; sb = '0; bv = '0;
    if (hi) begin
      isExc = 1'b1;
      return;
    end
    for (int b = 0; b < 6; b++) begin
      if (ex[b] && !isExc) begin
        isExc = 1'b1;
        ec = CODE_TAB[b];
        sb = (b == 5) ? 9'd1 : 9'd0;
        bv = (b == 0) ? pc : ((b >= 4) ? va : 32'h0);
      end
    end
  endfunction

  // Whole trap transaction from the commit cycle T through the last drain cycle.
  task automatic runTrap(input string name, input logic hi, input logic [5:0] ex, input logic ertn,
                         input logic [31:0] pc, input logic [31:0] va, input logic [31:0] entry,
                         input logic [31:0] era, input int waitN);
    logic isExc;
    logic [5:0] ec;
    logic [8:0] sb;
    logic [31:0] bv, target;
    logic [4:0] expFlags;
    classify(hi, ex, pc, va, isExc, ec, sb, bv);
    target = isExc ? entry : era;

    wb_valid = 1'b1; wb_exc = ex; wb_is_ertn = ertn; has_int = hi; wb_pc = pc; wb_vaddr = va;
    redir_ready = 1'($urandom);
    #1;
    nChecks++;
    if ({commit_kill, busy} !== 2'b10) $display("[TB] FAIL %s commit kill/busy got %b want 10", name, {commit_kill, busy});
    else nPass++;
    cycle();

    for (int i = 0; i <= waitN; i++) begin
      randomWb();
      ex_entry = (i == 0) ? entry : $urandom;
      ertn_pc  = (i == 0) ? era : $urandom;
      redir_ready = (i == waitN);
      #1;
      expFlags = {1'b1, 1'b1, i == 0, (i == 0) && isExc, (i == 0) && !isExc};
      nChecks++;
      if ({busy, redir_valid, flush, csr_wb_ex, csr_ertn_flush} !== expFlags)
        $display("[TB] FAIL %s redir flags cyc%0d got %b want %b", name, i,
                 {busy, redir_valid, flush, csr_wb_ex, csr_ertn_flush}, expFlags);
      else nPass++;
      nChecks++;
      if (redir_pc !== target) $display("[TB] FAIL %s redir_pc cyc%0d got %h want %h", name, i, redir_pc, target);
      else nPass++;
      nChecks++;
      if (commit_kill !== wb_valid) $display("[TB] FAIL %s kill in REDIR got %b want %b", name, commit_kill, wb_valid);
      else nPass++;
      if (i == 0 && isExc) begin
        heldEcode = ec; heldSub = sb; heldPc = pc; heldVaddr = bv;
      end
      nChecks++;
      if ({csr_ecode, csr_esubcode, csr_pc, csr_vaddr} !== {heldEcode, heldSub, heldPc, heldVaddr})
        $display("[TB] FAIL %s csr info got %h/%h/%h/%h want %h/%h/%h/%h", name, csr_ecode, csr_esubcode,
                 csr_pc, csr_vaddr, heldEcode, heldSub, heldPc, heldVaddr);
      else nPass++;
      cycle();
    end

    for (int d = 0; d < DRAIN; d++) begin
      randomWb();
      wb_exc = 6'b001000;
      redir_ready = 1'($urandom);
      #1;
      nChecks++;
      if ({busy, redir_valid, flush, csr_wb_ex, csr_ertn_flush, commit_kill} !== {5'b10000, wb_valid})
        $display("[TB] FAIL %s drain cyc%0d got %b want %b", name, d,
                 {busy, redir_valid, flush, csr_wb_ex, csr_ertn_flush, commit_kill}, {5'b10000, wb_valid});
      else nPass++;
      cycle();
    end
  endtask

  // One IDLE cycle with no trap; optionally a non-trapping commit that must not be killed.
  task automatic idleCycle(input string name, input logic commitOk);
    wb_valid = commitOk; wb_exc = '0; wb_is_ertn = 1'b0;
    has_int = commitOk ? 1'b0 : 1'($urandom);
    #1;
    nChecks++;
    if ({busy, redir_valid, flush, csr_wb_ex, csr_ertn_flush, commit_kill} !== 6'b0)
      $display("[TB] FAIL %s idle got %b want 000000", name,
               {busy, redir_valid, flush, csr_wb_ex, csr_ertn_flush, commit_kill});
    else nPass++;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    #1;
    nChecks++;
    if ({commit_kill, csr_wb_ex, csr_ertn_flush, csr_ecode, csr_esubcode, csr_pc, csr_vaddr,
         flush, redir_valid, redir_pc, busy} !== '0)
      $display("[TB] FAIL reset outputs got nonzero kill=%b ex=%b ertn=%b ecode=%h pc=%h busy=%b want all 0",
               commit_kill, csr_wb_ex, csr_ertn_flush, csr_ecode, csr_pc, busy);
    else nPass++;
    cycle();
  endtask

  task automatic test_ine();
    runTrap("ine", 1'b0, 6'b000010, 1'b0, 32'h1c000100, 32'h0, 32'h1c008000, 32'h0, 0);
    idleCycle("ine_after", 1'b0);
  endtask

  task automatic test_priority();
    runTrap("ale_adem", 1'b0, 6'b110000, 1'b0, 32'h1c000200, 32'h00001003, 32'h1c008000, 32'h0, 1);
    runTrap("adef_ine", 1'b0, 6'b000011, 1'b0, 32'h1c000303, 32'h00002000, 32'h1c008000, 32'h0, 0);
    runTrap("adem", 1'b0, 6'b100000, 1'b0, 32'h1c000400, 32'h00004002, 32'h1c008000, 32'h0, 0);
  endtask

  task automatic test_ertn();
    runTrap("ertn", 1'b0, 6'b0, 1'b1, 32'h1c000500, 32'h0, 32'h1c008000, 32'h1c000204, 5);
    idleCycle("ertn_after", 1'b1);
  endtask

  task automatic test_int();
    runTrap("int_sys", 1'b1, 6'b000100, 1'b0, 32'h1c000600, 32'h0, 32'h1c008040, 32'h0, 0);
    runTrap("int_ertn", 1'b1, 6'b0, 1'b1, 32'h1c000700, 32'h0, 32'h1c008080, 32'h1c000abc, 2);
    wb_valid = 1'b0; wb_exc = 6'b000100; has_int = 1'b1;
    #1;
    nChecks++;
    if (commit_kill !== 1'b0) $display("[TB] FAIL int_novalid kill got %b want 0", commit_kill);
    else nPass++;
    cycle();
    idleCycle("int_novalid_next", 1'b0);
  endtask

  task automatic test_back_to_back();
    runTrap("brk_first", 1'b0, 6'b001000, 1'b0, 32'h1c000800, 32'h0, 32'h1c008000, 32'h0, 0);
    runTrap("brk_second", 1'b0, 6'b001000, 1'b0, 32'h1c000804, 32'h0, 32'h1c0080c0, 32'h0, 1);
  endtask

  task automatic test_random();
    logic hi, ertn;
    logic [5:0] ex;
    for (int n = 0; n < 40; n++) begin
      hi = ($urandom_range(0, 3) == 0);
      ex = ($urandom_range(0, 2) == 0) ? 6'b0 : 6'($urandom);
      ertn = 1'($urandom);
      if (!hi && ex == 6'b0) ertn = 1'b1;
      runTrap("random", hi, ex, ertn, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idleCycle("random_idle", 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_exc = 6'b000010; wb_is_ertn = 1'b0; has_int = 1'b0; wb_pc = 32'h1c000900;
    redir_ready = 1'b0;
    cycle();
    wb_valid = 1'b0; ex_entry = 32'h1c008100;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    nChecks++;
    if ({redir_valid, busy, flush, csr_wb_ex, csr_ertn_flush, csr_ecode} !== '0)
      $display("[TB] FAIL reset_mid got rv=%b busy=%b fl=%b ex=%b er=%b ec=%h want all 0",
               redir_valid, busy, flush, csr_wb_ex, csr_ertn_flush, csr_ecode);
    else nPass++;
    heldEcode = '0; heldSub = '0; heldPc = '0; heldVaddr = '0;
    cycle();
    idleCycle("reset_mid_next", 1'b0);
    runTrap("after_reset", 1'b0, 6'b000100, 1'b0, 32'h1c000a00, 32'h0, 32'h1c008000, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_ine();
    test_priority();
    test_ertn();
    test_int();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
